// File: rtl/glb_load_sequencer.sv
// -----------------------------------------------------------------------------
// glb_load_sequencer
//
// Steers the single 32-bit DRAM input stream into the three global buffers
// (ifmap, weight, bias) ahead of each layer. Each phase length is configured
// per layer. A zero length skips that phase. Phases always run in the order
// ifmap -> weight -> bias. load_done hands the layer over to the compute
// controller.
//
// Optional feature (compile-time macro LOAD_CHECKSUM_EN):
//   defined   : checksum is a wrapping 32-bit sum of every accepted beat since
//               the last accepted start. It is valid while load_done is high
//               and holds afterwards.
//   undefined : checksum is tied to 0 and no adder is built.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     one-cycle pulse, begins a layer load (IDLE only)
//   cfg_ifmap_words           ifmap words to load (0 = skip)
//   cfg_weight_words          weight words to load (0 = skip)
//   cfg_bias_words            bias words to load (0 = skip)
//   in_valid, in_data         DRAM beat
//   in_ready                  loader accepts a beat this cycle
//   ifmap_wen, weight_wen,
//   bias_wen                  SRAM write strobes (at most one high)
//   wr_addr, wr_data          word address / data for the strobed SRAM
//   busy                      high from accepted start through the done cycle
//   load_done                 one-cycle pulse, all phases written
//   cfg_err                   one-cycle pulse, start rejected (length > capacity)
//   checksum                  see optional feature above
// -----------------------------------------------------------------------------
module glb_load_sequencer #(
  parameter int ADDR_W       = 12,
  parameter int IFMAP_WORDS  = 32,
  parameter int WEIGHT_WORDS = 1024,
  parameter int BIAS_WORDS   = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_ifmap_words,
  input  logic [ADDR_W-1:0] cfg_weight_words,
  input  logic [ADDR_W-1:0] cfg_bias_words,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              ifmap_wen,
  output logic              weight_wen,
  output logic              bias_wen,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              load_done,
  output logic              cfg_err,
  output logic [31:0]       checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IFMAP,
    S_WEIGHT,
    S_BIAS,
    S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cfg_if;
  logic [ADDR_W-1:0] cfg_wt;
  logic [ADDR_W-1:0] cfg_bs;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cur_len;
  logic              accept;
  logic              last_beat;
  logic              cfg_bad;
  logic              start_ok;

  // Phase that follows 'cur', skipping zero-length phases. Called with
  // cur = S_IFMAP at start time when the ifmap length itself is zero, which
  // yields the first non-empty phase after ifmap.
  function automatic state_t next_phase(input state_t            cur,
                                        input logic [ADDR_W-1:0] wt,
                                        input logic [ADDR_W-1:0] bs);
    state_t nxt;
    nxt = S_DONE;
    case (cur)
      S_IFMAP: begin
        if (wt != '0)      nxt = S_WEIGHT;
        else if (bs != '0) nxt = S_BIAS;
      end
      S_WEIGHT: begin
        if (bs != '0)      nxt = S_BIAS;
      end
      default: nxt = S_DONE;
    endcase
    return nxt;
  endfunction

  assign cfg_bad = (cfg_ifmap_words  > ADDR_W'(IFMAP_WORDS))  ||
                   (cfg_weight_words > ADDR_W'(WEIGHT_WORDS)) ||
                   (cfg_bias_words   > ADDR_W'(BIAS_WORDS));

  assign start_ok  = (state == S_IDLE) && start && !cfg_bad;
  assign in_ready  = (state == S_IFMAP) || (state == S_WEIGHT) || (state == S_BIAS);
  assign accept    = in_valid && in_ready;
  assign busy      = (state != S_IDLE);
  assign load_done = (state == S_DONE);

  always_comb begin
    cur_len = '0;
    case (state)
      S_IFMAP:  cur_len = cfg_if;
      S_WEIGHT: cur_len = cfg_wt;
      S_BIAS:   cur_len = cfg_bs;
      default:  cur_len = '0;
    endcase
  end

  assign last_beat = accept && (cnt == (cur_len - ADDR_W'(1)));

  // Stage p0 -> p1: accepted beat becomes an SRAM write one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cfg_if     <= '0;
      cfg_wt     <= '0;
      cfg_bs     <= '0;
      ifmap_wen  <= 1'b0;
      weight_wen <= 1'b0;
      bias_wen   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err    <= 1'b0;
      ifmap_wen  <= 1'b0;
      weight_wen <= 1'b0;
      bias_wen   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cfg_if <= cfg_ifmap_words;
            cfg_wt <= cfg_weight_words;
            cfg_bs <= cfg_bias_words;
            cnt    <= '0;
            if (cfg_bad)
              cfg_err <= 1'b1;
            else if (cfg_ifmap_words != '0)
              state <= S_IFMAP;
            else
              state <= next_phase(S_IFMAP, cfg_weight_words, cfg_bias_words);
          end
        end
        S_IFMAP, S_WEIGHT, S_BIAS: begin
          if (accept) begin
            ifmap_wen  <= (state == S_IFMAP);
            weight_wen <= (state == S_WEIGHT);
            bias_wen   <= (state == S_BIAS);
            wr_addr    <= cnt;
            wr_data    <= in_data;
            // Clearing on the last beat lets the next phase take a beat in
            // the very next cycle.
            if (last_beat) begin
              cnt   <= '0;
              state <= next_phase(state, cfg_wt, cfg_bs);
            end else begin
              cnt <= cnt + ADDR_W'(1);
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LOAD_CHECKSUM_EN
  logic [31:0] sum_p1;

  // Stage p0 -> p1: sum advances in the same cycle as the matching write
  always_ff @(posedge clk) begin
    if (rst)
      sum_p1 <= '0;
    else if (start_ok)
      sum_p1 <= '0;
    else if (accept)
      sum_p1 <= sum_p1 + in_data;
  end

  assign checksum = sum_p1;
`else
  assign checksum = '0;
`endif

endmodule
